// File: rtl/stq_fwd_ctrl.sv
// Store-queue pointer/valid-bit control with a registered store-to-load forwarding selector.
// Picks the youngest older store whose address matches the load, or flags a replay.
module stq_fwd_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned INDEX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_i,
  output logic             allocReady_o,
  output logic [INDEX:0]   allocPtr_o,
  input  logic             addrWe_i,
  input  logic [INDEX-1:0] addrWrIdx_i,
  input  logic             dataWe_i,
  input  logic [INDEX-1:0] dataWrIdx_i,
  input  logic             commit_i,
  input  logic             flush_i,
  input  logic [INDEX:0]   flushTail_i,
  input  logic             ldReq_i,
  input  logic [INDEX:0]   ldStqTail_i,
  input  logic [DEPTH-1:0] camVect_i,
  output logic             fwdValid_o,
  output logic             fwdHit_o,
  output logic [INDEX-1:0] fwdIdx_o,
  output logic             fwdDataRdy_o,
  output logic             fwdReplay_o,
  output logic [INDEX:0]   count_o
);

  localparam logic [INDEX:0] DepthP = (INDEX+1)'(DEPTH);

  logic [INDEX:0]   head_q, head_d, tail_q, tail_d, count;
  logic [INDEX-1:0] head_idx, tail_idx;
  logic             full, empty, do_alloc, do_commit;
  logic [INDEX:0]   flush_cnt, older_raw, older_cnt;
  logic [DEPTH-1:0] valid_q, valid_d, addr_valid_q, addr_valid_d, data_valid_q, data_valid_d;
  logic [DEPTH-1:0] kill;

  logic             srch_hit, srch_replay;
  logic [INDEX-1:0] srch_idx, e;

  logic             fwd_valid_q, fwd_hit_q, fwd_rdy_q, fwd_replay_q;
  logic [INDEX-1:0] fwd_idx_q;

  assign head_idx  = head_q[INDEX-1:0];
  assign tail_idx  = tail_q[INDEX-1:0];
  assign count     = tail_q - head_q;
  assign full      = (count == DepthP);
  assign empty     = (count == '0);
  assign do_alloc  = alloc_i & ~full & ~flush_i;
  assign do_commit = commit_i & ~empty;
  assign flush_cnt = flushTail_i - head_q;

  always_comb begin
    head_d       = do_commit ? head_q + 1'b1 : head_q;
    tail_d       = flush_i ? flushTail_i : (do_alloc ? tail_q + 1'b1 : tail_q);
    valid_d      = valid_q;
    addr_valid_d = addr_valid_q;
    data_valid_d = data_valid_q;
    kill         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Entries at or beyond the recovered tail offset are squashed.
      kill[i] = (do_commit && INDEX'(i) == head_idx) ||
                (flush_i && {1'b0, INDEX'(i) - head_idx} >= flush_cnt);
      if (kill[i] || (do_alloc && INDEX'(i) == tail_idx)) begin
        valid_d[i]      = ~kill[i];
        addr_valid_d[i] = 1'b0;
        data_valid_d[i] = 1'b0;
      end else begin
        if (addrWe_i && addrWrIdx_i == INDEX'(i) && valid_q[i]) addr_valid_d[i] = 1'b1;
        if (dataWe_i && dataWrIdx_i == INDEX'(i) && valid_q[i]) data_valid_d[i] = 1'b1;
      end
    end
  end

  // A snapshot behind head wraps to a large value; such a load sees no older stores.
  assign older_raw = ldStqTail_i - head_q;
  assign older_cnt = (older_raw > DepthP) ? '0 : older_raw;

  // Walk from oldest to youngest: the last candidate wins, and only unknown
  // addresses seen after it can require a replay.
  always_comb begin
    srch_hit    = 1'b0;
    srch_replay = 1'b0;
    srch_idx    = '0;
    e           = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      e = head_idx + INDEX'(k);
      if (valid_q[e] && ({1'b0, INDEX'(k)} < older_cnt)) begin
        if (addr_valid_q[e]) begin
          if (camVect_i[e]) begin
            srch_hit    = 1'b1;
            srch_idx    = e;
            srch_replay = 1'b0;
          end
        end else begin
          srch_replay = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      addr_valid_q <= '0;
      data_valid_q <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_hit_q    <= 1'b0;
      fwd_idx_q    <= '0;
      fwd_rdy_q    <= 1'b0;
      fwd_replay_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      addr_valid_q <= addr_valid_d;
      data_valid_q <= data_valid_d;
      fwd_valid_q  <= ldReq_i;
      fwd_hit_q    <= ldReq_i & srch_hit;
      fwd_idx_q    <= (ldReq_i & srch_hit) ? srch_idx : '0;
      fwd_rdy_q    <= ldReq_i & srch_hit & data_valid_q[srch_idx];
      fwd_replay_q <= ldReq_i & srch_replay;
    end
  end

  assign allocReady_o = ~full;
  assign allocPtr_o   = tail_q;
  assign count_o      = count;
  assign fwdValid_o   = fwd_valid_q;
  assign fwdHit_o     = fwd_hit_q;
  assign fwdIdx_o     = fwd_idx_q;
  assign fwdDataRdy_o = fwd_rdy_q;
  assign fwdReplay_o  = fwd_replay_q;

endmodule
